axi_lite_sram_slave: RTL

AXI4-Lite slave memory that sits directly downstream of the MIPS CPU top-level AXI adapter and serves both instruction fetches and data loads/stores issued on its AR/R and AW/W/B channels. It holds a word-addressed SRAM with byte-strobe writes. It runs independent single-outstanding read and write engines. Read latency is configurable so CPU handshake stalls can be exercised in simulation and on the FPGA platform.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/sram_bytewise.sv | 33 +++
 rtl/axi_lite_sram_slave.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state types and address decode helper for the
// AXI4-Lite SRAM slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_VALID = 2'd2
  } rd_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  // True when no address bit above the word-index field is set.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned addr_width);
    return (addr >> (addr_width + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/sram_bytewise.sv
// Simple dual-port 32-bit word memory with byte write enables and a
// registered read port. No reset so it can map onto block RAM. A read and a
// write to the same word on the same edge return the pre-write contents.
module sram_bytewise #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strb
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Registered read and byte-masked write sharing one clock edge.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave in front of a word-addressed SRAM. Independent
// single-outstanding read and write engines; read latency set by RD_LATENCY.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        mips_cpu_clk,
  input  logic        mips_cpu_reset,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY - 1);

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  rd_state_t             rd_state;
  logic [3:0]            rd_cnt;
  logic [ADDR_WIDTH-1:0] rd_index;
  logic                  rd_in_range;
  logic                  rd_data_ok;
  logic                  rd_sample;
  logic                  sram_rd_en;
  logic [31:0]           sram_q;

  assign rd_sample  = (rd_state == R_WAIT) && (rd_cnt == 4'd0);
  assign sram_rd_en = rd_sample && rd_in_range;

  // The SRAM output register doubles as the rdata register; rd_data_ok masks
  // it to zero after reset and for out-of-range reads.
  assign s_axi_rdata = rd_data_ok ? sram_q : '0;

  // Read FSM: accept AR, count down the latency, present R until accepted.
  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset) begin
      rd_state      <= R_IDLE;
      rd_cnt        <= '0;
      rd_index      <= '0;
      rd_in_range   <= 1'b0;
      rd_data_ok    <= 1'b0;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            rd_index      <= s_axi_araddr[ADDR_WIDTH+1:2];
            rd_in_range   <= addr_in_range(s_axi_araddr, ADDR_WIDTH);
            rd_cnt        <= RD_CNT_INIT;
            s_axi_arready <= 1'b0;
            rd_state      <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt == 4'd0) begin
            rd_data_ok   <= rd_in_range;
            s_axi_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            s_axi_rvalid <= 1'b1;
            rd_state     <= R_VALID;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_VALID: begin
          if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= R_IDLE;
          end
        end
        default: begin
          s_axi_rvalid  <= 1'b0;
          s_axi_arready <= 1'b1;
          rd_state      <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  wr_state_t             wr_state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] wr_index_q;
  logic                  wr_in_range_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_index;
  logic                  wr_in_range;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  sram_wr_en;

  // Merge held and in-flight AW/W so the write commits on the edge that
  // completes the pair, whichever channel arrives last.
  always_comb begin
    aw_hs       = s_axi_awvalid && s_axi_awready;
    w_hs        = s_axi_wvalid && s_axi_wready;
    commit      = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    wr_index    = aw_held ? wr_index_q : s_axi_awaddr[ADDR_WIDTH+1:2];
    wr_in_range = aw_held ? wr_in_range_q : addr_in_range(s_axi_awaddr, ADDR_WIDTH);
    wr_data     = w_held ? wdata_q : s_axi_wdata;
    wr_strb     = w_held ? wstrb_q : s_axi_wstrb;
  end

  // Reset gates the write enable so an edge seen during reset never commits.
  assign sram_wr_en = commit && wr_in_range && !mips_cpu_reset;

  // Write FSM: capture AW and W independently, commit, then hold B.
  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset) begin
      wr_state      <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      wr_index_q    <= '0;
      wr_in_range_q <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held       <= 1'b1;
            wr_index_q    <= s_axi_awaddr[ADDR_WIDTH+1:2];
            wr_in_range_q <= addr_in_range(s_axi_awaddr, ADDR_WIDTH);
            s_axi_awready <= 1'b0;
          end
          if (w_hs) begin
            w_held       <= 1'b1;
            wdata_q      <= s_axi_wdata;
            wstrb_q      <= s_axi_wstrb;
            s_axi_wready <= 1'b0;
          end
          if (commit) begin
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            wr_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: begin
          aw_held       <= 1'b0;
          w_held        <= 1'b0;
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b1;
          wr_state      <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sram_bytewise #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk     (mips_cpu_clk),
    .rd_en   (sram_rd_en),
    .rd_addr (rd_index),
    .rd_data (sram_q),
    .wr_en   (sram_wr_en),
    .wr_addr (wr_index),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

endmodule
